// File: rtl/game_ctrl_pkg.sv
// rtl/game_ctrl_pkg.sv - shared types, constants and helpers for the game controller
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    DROP  = 3'd2,
    CHECK = 3'd3,
    SPAWN = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam int         COLS         = 10;
  localparam int         ROWS         = 20;
  localparam logic [3:0] PLAYER_START = 4'd5;
  localparam logic [7:0] LFSR_SEED    = 8'hA5;

  // Terminal tick count for a level; periods that shift down to 0 or 1 wait a single cycle.
  function automatic logic [31:0] tick_last(input int unsigned div, input logic [2:0] lvl);
    logic [31:0] period;
    period = 32'(div) >> lvl;
    return (period <= 32'd1) ? 32'd0 : period - 32'd1;
  endfunction

  function automatic logic [3:0] col_of(input logic [3:0] v);
    return (v >= 4'd10) ? v - 4'd10 : v;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1
module lfsr8
  import game_ctrl_pkg::*;
(
  input  logic       CLK_50,
  input  logic       reset,
  output logic [7:0] q
);

  always_ff @(posedge CLK_50) begin
    if (reset) q <= LFSR_SEED;
    else       q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - falling-block game sequencer: drop timing, spawning, player, scoring
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int TICK_DIV    = 2500000,
  parameter int SPAWN_EVERY = 3,
  parameter int COLS        = game_ctrl_pkg::COLS
) (
  input  logic        CLK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        collide,
  output logic        drop_en,
  output logic        spawn_en,
  output logic [3:0]  spawn_col,
  output logic [3:0]  player_x,
  output logic [15:0] score,
  output logic [2:0]  level,
  output logic        game_over
);

  localparam logic [3:0]  X_MAX      = 4'(COLS - 1);
  localparam logic [15:0] SPAWN_LAST = 16'(SPAWN_EVERY - 1);

  state_t      state, state_n;
  logic [31:0] tick_cnt, tick_n;
  logic [15:0] spawn_cnt, spawn_n;
  logic [15:0] score_n;
  logic [3:0]  px_n;
  logic [2:0]  level_n;
  logic [7:0]  lfsr_q;

  lfsr8 u_lfsr (
    .CLK_50 (CLK_50),
    .reset  (reset),
    .q      (lfsr_q)
  );

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      spawn_cnt <= '0;
      player_x  <= PLAYER_START;
      score     <= '0;
      level     <= '0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      spawn_cnt <= spawn_n;
      player_x  <= px_n;
      score     <= score_n;
      level     <= level_n;
    end
  end

  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt;
    spawn_n   = spawn_cnt;
    px_n      = player_x;
    score_n   = score;
    level_n   = level;
    drop_en   = 1'b0;
    spawn_en  = 1'b0;
    spawn_col = 4'd0;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_n = WAIT;
          tick_n  = '0;
          spawn_n = '0;
          score_n = '0;
          level_n = '0;
          px_n    = PLAYER_START;
        end
      end
      WAIT: begin
        if (tick_cnt >= tick_last(TICK_DIV, level)) begin
          tick_n  = '0;
          state_n = DROP;
        end else begin
          tick_n = tick_cnt + 32'd1;
        end
        // Simultaneous left+right cancels out.
        if (move_left && !move_right && player_x != 4'd0)
          px_n = player_x - 4'd1;
        else if (move_right && !move_left && player_x < X_MAX)
          px_n = player_x + 4'd1;
      end
      DROP: begin
        drop_en = 1'b1;
        state_n = CHECK;
      end
      CHECK: begin
        if (collide) begin
          state_n = OVER;
        end else begin
          if (score != 16'hFFFF) begin
            score_n = score + 16'd1;
            if (score_n[3:0] == 4'd0 && level != 3'd7) level_n = level + 3'd1;
          end
          if (spawn_cnt == SPAWN_LAST) begin
            spawn_n = '0;
            state_n = SPAWN;
          end else begin
            spawn_n = spawn_cnt + 16'd1;
            state_n = WAIT;
          end
        end
      end
      SPAWN: begin
        spawn_en  = 1'b1;
        spawn_col = col_of(lfsr_q[3:0]);
        state_n   = WAIT;
      end
      default: state_n = IDLE;
    endcase
  end

  assign game_over = (state == OVER);

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl
module tb_game_ctrl;
  import game_ctrl_pkg::*;

  logic        CLK_50 = 1'b0;
  logic        reset = 1'b1, start = 1'b0, move_left = 1'b0, move_right = 1'b0, collide = 1'b0;
  logic        drop_en, spawn_en, game_over;
  logic [3:0]  spawn_col, player_x;
  logic [15:0] score;
  logic [2:0]  level;

  int checks = 0, failures = 0;
  int drops_cnt = 0;
  logic both_strobes = 1'b0;

  game_ctrl #(.TICK_DIV(8), .SPAWN_EVERY(3), .COLS(10)) dut (
    .CLK_50(CLK_50), .reset(reset), .start(start), .move_left(move_left),
    .move_right(move_right), .collide(collide), .drop_en(drop_en), .spawn_en(spawn_en),
    .spawn_col(spawn_col), .player_x(player_x), .score(score), .level(level),
    .game_over(game_over)
  );

  always #5 CLK_50 = ~CLK_50;

  always @(posedge CLK_50) begin
    if (drop_en) drops_cnt <= drops_cnt + 1;
    if (drop_en && spawn_en) both_strobes <= 1'b1;
  end

  task automatic tick;
    @(posedge CLK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_drop(output int n);
    n = 0;
    while (drop_en !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("drop_timeout", 32'(drop_en), 32'd1);
  endtask

  task automatic wait_state_wait;
    int k;
    k = 0;
    while (dut.state !== WAIT && k < 200) begin
      tick();
      k++;
    end
    chk("wait_timeout", 32'(dut.state), 32'(WAIT));
  endtask

  task automatic do_move(input logic l, input logic r);
    wait_state_wait();
    move_left  = l;
    move_right = r;
    tick();
    move_left  = 1'b0;
    move_right = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, d0, exp_p, lvl, prev_spawn;
    logic [3:0] px;

    // Reset values
    tick(); tick();
    chk("rst_drop_en", 32'(drop_en), 32'd0);
    chk("rst_spawn_en", 32'(spawn_en), 32'd0);
    chk("rst_spawn_col", 32'(spawn_col), 32'd0);
    chk("rst_player_x", 32'(player_x), 32'd5);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_lfsr", 32'(dut.u_lfsr.q), 32'hA5);
    reset = 1'b0;
    tick();
    chk("idle_state", 32'(dut.state), 32'(IDLE));

    // Game A: first-drop latency
    start = 1'b1; tick(); start = 1'b0;
    wait_drop(n);
    chk("first_drop_latency", 32'(n), 32'd8);
    tick();
    chk("check_after_drop", 32'(dut.state), 32'(CHECK));
    chk("check_drop_en_low", 32'(drop_en), 32'd0);
    tick();
    chk("score_after_drop1", 32'(score), 32'd1);

    // Player movement and edges
    repeat (6) do_move(1'b1, 1'b0);
    chk("left_edge", 32'(player_x), 32'd0);
    wait_drop(n);
    move_right = 1'b1; tick(); move_right = 1'b0;
    chk("move_outside_wait", 32'(player_x), 32'd0);
    repeat (10) do_move(1'b0, 1'b1);
    chk("right_edge", 32'(player_x), 32'd9);
    do_move(1'b1, 1'b1);
    chk("both_moves_ignored", 32'(player_x), 32'd9);
    do_move(1'b1, 1'b0);
    chk("left_from_9", 32'(player_x), 32'd8);

    // start while playing is ignored
    wait_state_wait();
    s = int'(score);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_in_wait_score", 32'(score), 32'(s));
    chk("start_in_wait_px", 32'(player_x), 32'd8);

    // Collision ends the game
    wait_drop(n);
    s = int'(score);
    collide = 1'b1;
    tick();
    tick();
    collide = 1'b0;
    chk("collide_game_over", 32'(game_over), 32'd1);
    chk("collide_score_frozen", 32'(score), 32'(s));
    px = player_x;
    d0 = drops_cnt;
    repeat (10) tick();
    move_right = 1'b1; tick(); move_right = 1'b0;
    move_left = 1'b1; tick(); move_left = 1'b0;
    repeat (20) tick();
    chk("over_no_drops", 32'(drops_cnt), 32'(d0));
    chk("over_px_frozen", 32'(player_x), 32'(px));
    chk("over_held", 32'(game_over), 32'd1);
    chk("over_score_frozen", 32'(score), 32'(s));

    // Restart from OVER
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_px", 32'(player_x), 32'd5);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_level", 32'(level), 32'd0);
    chk("restart_game_over", 32'(game_over), 32'd0);

    // Game B: 1000 drops without collision
    prev_spawn = 0;
    for (int i = 1; i <= 1000; i++) begin
      lvl = ((i - 1) / 16 > 7) ? 7 : (i - 1) / 16;
      exp_p = 8 >> lvl;
      if (exp_p < 1) exp_p = 1;
      wait_drop(n);
      chk("drop_period", 32'(n), 32'(exp_p + prev_spawn));
      tick();
      tick();
      chk("spawn_on_3rd", 32'(spawn_en), 32'((i % 3) == 0));
      if (spawn_en === 1'b1) chk("spawn_col_range", 32'(spawn_col <= 4'd9), 32'd1);
      chk("score_count", 32'(score), 32'(i));
      chk("level_model", 32'(level), 32'((i / 16 > 7) ? 7 : i / 16));
      prev_spawn = ((i % 3) == 0) ? 1 : 0;
    end
    chk("no_dual_strobe", 32'(both_strobes), 32'd0);

    // Reset in DROP
    wait_drop(n);
    reset = 1'b1;
    tick();
    chk("mid_rst_drop_en", 32'(drop_en), 32'd0);
    chk("mid_rst_spawn_en", 32'(spawn_en), 32'd0);
    chk("mid_rst_spawn_col", 32'(spawn_col), 32'd0);
    chk("mid_rst_player_x", 32'(player_x), 32'd5);
    chk("mid_rst_score", 32'(score), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_game_over", 32'(game_over), 32'd0);
    chk("mid_rst_lfsr", 32'(dut.u_lfsr.q), 32'hA5);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    tick();
    chk("post_rst_idle", 32'(dut.state), 32'(IDLE));
    chk("post_rst_drop_en", 32'(drop_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
